// File: rtl/exhaustive_vector_misr.sv
// Exhaustive-vector sweep harness: drives every input vector of a small cell in
// ascending order, compacts the sampled responses in a MISR and checks a golden value.
module exhaustive_vector_misr #(
  parameter int                   N_WIDTH       = 4,
  parameter int                   SETTLE_CYCLES = 1,
  parameter int                   SIG_WIDTH     = 16,
  parameter logic [SIG_WIDTH-1:0] POLY          = 16'h002D,
  parameter logic [SIG_WIDTH-1:0] GOLDEN        = 16'h0000
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [0:N_WIDTH-1]   vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
  output logic                 rec_valid,
  output logic [0:N_WIDTH-1]   rec_vec,
  output logic                 rec_out
);

  localparam int                 CNT_W       = 4;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [N_WIDTH-1:0] VEC_ONE     = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] VEC_LAST    = {N_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // One MISR step: shift left, fold the outgoing MSB back through POLY, inject the response.
  function automatic logic [SIG_WIDTH-1:0] misr_step(
    input logic [SIG_WIDTH-1:0] sig,
    input logic                 bit_in
  );
    logic [SIG_WIDTH-1:0] fb;
    fb = sig[SIG_WIDTH-1] ? POLY : {SIG_WIDTH{1'b0}};
    return {sig[SIG_WIDTH-2:0], 1'b0} ^ fb ^ {{(SIG_WIDTH-1){1'b0}}, bit_in};
  endfunction

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rec_valid_q, rec_valid_d;
  logic [N_WIDTH-1:0]   rec_vec_q, rec_vec_d;
  logic                 rec_out_q, rec_out_d;

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    rec_valid_d = 1'b0;
    rec_vec_d   = rec_vec_q;
    rec_out_d   = rec_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = {N_WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          sig_d   = {SIG_WIDTH{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        sig_d       = misr_step(sig_q, dut_out);
        rec_valid_d = 1'b1;
        rec_vec_d   = vec_q;
        rec_out_d   = dut_out;
        // The sweep stops at all ones; the counter never wraps back to zero.
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vec_q       <= {N_WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      sig_q       <= {SIG_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_vec_q   <= {N_WIDTH{1'b0}};
      rec_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rec_valid_q <= rec_valid_d;
      rec_vec_q   <= rec_vec_d;
      rec_out_q   <= rec_out_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (sig_q == GOLDEN);
  assign signature = sig_q;
  assign rec_valid = rec_valid_q;
  assign rec_vec   = rec_vec_q;
  assign rec_out   = rec_out_q;

endmodule

// File: doc/exhaustive_vector_misr.md
# exhaustive_vector_misr

Synthesizable on-chip harness for the 4-input, single-output trojan-detection benchmark cells.
- Upstream of the cell: drives every input vector in ascending binary order, 0 to 2^N_WIDTH-1.
- Downstream of the cell: samples the single output once per vector, compacts the responses into a MISR signature and compares it with a golden value.
- Also emits a per-vector record stream so the existing "vector response" text logging continues unchanged.

## Interface
Parameters:
- N_WIDTH, 4, number of cell inputs; vectors swept = 2^N_WIDTH.
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..15.
- SIG_WIDTH, 16, MISR width.
- POLY, 16'h002D, MISR feedback mask (x^16+x^5+x^3+x^2+1).
- GOLDEN, 16'h0000, expected final signature.

Ports:
- CK, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, begin a sweep; sampled only in IDLE or DONE.
- dut_out, input, 1, cell output (output_single).
- vec, output, [0:N_WIDTH-1], cell input vector; vec[0] is the MSB of the count.
- busy, output, 1, high in DRIVE and SAMPLE.
- done, output, 1, high in DONE.
- pass, output, 1, (signature == GOLDEN); valid only while done.
- signature, output, SIG_WIDTH, current MISR contents.
- rec_valid, output, 1, one-cycle pulse per sampled vector.
- rec_vec, output, [0:N_WIDTH-1], vector belonging to the record.
- rec_out, output, 1, sampled dut_out belonging to the record.

## Operation
FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**, start=1: next state DRIVE; vec=0, signature=0, settle counter=0.
- **DRIVE**: vec held stable; counter increments each cycle; after SETTLE_CYCLES cycles, next state SAMPLE.
- **SAMPLE** (one cycle); at its closing edge:
  - signature <= (signature<<1) ^ (signature[MSB] ? POLY : 0) ^ {0…0, dut_out}.
  - rec_vec <= vec, rec_out <= dut_out, rec_valid <= 1.
  - If vec is all ones: next state DONE, vec held.
  - Otherwise: vec <= vec+1, counter cleared, next state DRIVE.
- **DONE**: signature frozen; done=1; pass combinational from signature.
  - start=1 re-runs exactly as from IDLE, clearing signature.
- start is ignored in DRIVE and SAMPLE.
- rec_valid is low in every cycle not immediately following a SAMPLE edge.
- vec increments without wrap; the sweep ends at all ones.
- The MISR is not reseeded between vectors.

## Timing
- Reset (synchronous): at the next edge, state=IDLE, vec=0, signature=0, busy=0, done=0, rec_valid=0, rec_vec=0, rec_out=0. pass reads 0 outside DONE.
- Reset asserted mid-sweep aborts the sweep at that edge. No partial signature survives.
- reset and start both high: reset wins.
- Start accepted at edge t:
  - busy=1 and vec=0 from t+1.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done=1 at t+1+2^N_WIDTH*(SETTLE_CYCLES+1). With defaults: t+33.
- dut_out is sampled only at the SAMPLE edge, giving the cell SETTLE_CYCLES full cycles of settling.
- Each rec_valid pulse appears one cycle after its SAMPLE state. The final record's pulse coincides with the first DONE cycle.
- busy and done are never high together.
- Latency from start to the first rec_valid = SETTLE_CYCLES+2 cycles.

## Test plan
- **dut_out tied 0, defaults, start pulsed once**
  - 16 rec_valid pulses with rec_vec 0..15 in order, all rec_out=0.
  - done at start+33; signature=16'h0000; pass=1.
- **dut_out=1 only while vec=0**
  - Final signature=16'h8000 (single bit shifted 15 times, no feedback).
  - pass=0.
- **dut_out=1 only while vec=15**
  - Final signature=16'h0001.
  - rec_out=1 only on the last record.
- **SETTLE_CYCLES=3**
  - vec steps every 4 cycles; done at start+65.
  - dut_out toggled during DRIVE cycles but stable at SAMPLE: only SAMPLE-time values affect the signature.
- **reset asserted in cycle 10 of a sweep**
  - Next edge: all outputs at reset values.
  - A following start yields the same signature as an uninterrupted run.
- **start held high throughout the sweep, then again in DONE**
  - Mid-sweep start has no effect.
  - In DONE, start clears the signature, drops done and restarts at vec=0.
